// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI write-frame receiver.
package spi_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam int   FRAME_BITS   = 16;
   localparam logic RW_WRITE     = 1'b1;
   localparam int   CNT_W        = 5;
   localparam int   DEF_ADDR_W   = 7;
   localparam int   DEF_DATA_W   = 8;
   localparam int   DEF_MAX_ADDR = 4;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop pin synchronizer followed by a history flop for edge detection.
module spi_input_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_hist <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = o_level & ~r_hist;
   assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 16-bit write-frame deframer feeding the register bank.
// Build option: SPI_FRAME_RX_ADDR_ERR_EN flags out-of-range write addresses.
module spi_frame_rx
   import spi_frame_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MAX_ADDR    = DEF_MAX_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk_i,
   input  logic              copi_i,
   input  logic              ncs_i,
   output logic              wr_valid_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              frame_err_o,
   output logic              busy_o
);

   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_BITS + 1);
   localparam logic [ADDR_W-1:0] MAX_ADDR_C = ADDR_W'(MAX_ADDR);

   logic w_sclk_rise, w_sclk_level_unused, w_sclk_fall_unused;
   logic w_copi_level, w_copi_rise_unused, w_copi_fall_unused;
   logic w_ncs_rise, w_ncs_fall, w_ncs_level_unused;

   state_t                  r_state;
   logic [FRAME_BITS-1:0]   r_shift;
   logic [CNT_W-1:0]        r_bit_cnt;
   logic                    r_wr_valid;
   logic [ADDR_W-1:0]       r_wr_addr;
   logic [DATA_W-1:0]       r_wr_data;
   logic                    r_frame_err;

   logic                    w_rw;
   logic [ADDR_W-1:0]       w_addr;
   logic [DATA_W-1:0]       w_data;
   logic                    w_addr_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (cnt >= CNT_SAT) ? CNT_SAT : cnt + 1'b1;
   endfunction

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_pin(sclk_i),
      .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
   );

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .i_pin(copi_i),
      .o_level(w_copi_level), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
   );

   // nCS idles high, so its chain resets to 1 and a low pin after reset reads as a fall.
   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .i_pin(ncs_i),
      .o_level(w_ncs_level_unused), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
   );

   assign w_rw      = r_shift[FRAME_BITS-1];
   assign w_addr    = r_shift[FRAME_BITS-2 -: ADDR_W];
   assign w_data    = r_shift[DATA_W-1:0];
   assign w_addr_ok = (w_addr <= MAX_ADDR_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ncs_fall) begin
                  r_state   <= ST_SHIFT;
                  r_shift   <= '0;
                  r_bit_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               // End of frame takes priority over a coincident SCLK edge.
               if (w_ncs_rise) begin
                  r_state <= ST_CHECK;
               end else if (w_sclk_rise) begin
                  r_shift   <= {r_shift[FRAME_BITS-2:0], w_copi_level};
                  r_bit_cnt <= sat_inc(r_bit_cnt);
               end
            end
            ST_CHECK: begin
               r_state <= ST_IDLE;
               if (r_bit_cnt != CNT_FULL) begin
                  r_frame_err <= 1'b1;
               end else if (w_rw == RW_WRITE) begin
                  if (w_addr_ok) begin
                     r_wr_valid <= 1'b1;
                     r_wr_addr  <= w_addr;
                     r_wr_data  <= w_data;
                  end else begin
`ifdef SPI_FRAME_RX_ADDR_ERR_EN
                     r_frame_err <= 1'b1;
`else
                     r_frame_err <= 1'b0;
`endif
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr_valid_o  = r_wr_valid;
   assign wr_addr_o   = r_wr_addr;
   assign wr_data_o   = r_wr_data;
   assign frame_err_o = r_frame_err;
   assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: SCLK at clk/8, hand-computed frames.
module tb_spi_frame_rx;

   localparam int SYNC   = 2;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int HALF   = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sclk_i = 1'b0;
   logic              copi_i = 1'b0;
   logic              ncs_i = 1'b1;
   logic              wr_valid_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;
   logic              frame_err_o;
   logic              busy_o;

   spi_frame_rx #(.SYNC_STAGES(SYNC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(4)) dut (
      .clk(clk), .rst(rst), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
      .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .frame_err_o(frame_err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_wr = 0;
   int n_err = 0;
   int pulse_cyc = 0;
   int rise_cyc = 0;
   int wr0, err0;
   logic [ADDR_W-1:0] q_addr[$];
   logic [DATA_W-1:0] q_data[$];

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_valid_o) begin
            n_wr = n_wr + 1;
            q_addr.push_back(wr_addr_o);
            q_data.push_back(wr_data_o);
         end
         if (frame_err_o) n_err = n_err + 1;
         if (wr_valid_o || frame_err_o) pulse_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [16:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         copi_i = bits[i];
         sclk_i = 1'b0;
         tick(HALF);
         sclk_i = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic end_frame(input int gap);
      sclk_i = 1'b0;
      tick(HALF);
      ncs_i    = 1'b1;
      rise_cyc = cyc;
      tick(gap);
   endtask

   task automatic frame(input logic [16:0] bits, input int n, input int gap);
      ncs_i = 1'b0;
      tick(1);
      send_bits(bits, n);
      end_frame(gap);
   endtask

   task automatic mark();
      wr0  = n_wr;
      err0 = n_err;
   endtask

   task automatic chk_wr(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (q_addr.size() == 0) begin
         chk({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_addr"}, q_addr.pop_front(), a);
         chk({tag, "_data"}, q_data.pop_front(), d);
      end
   endtask

   initial begin
      tick(3);
      chk("rst_valid", wr_valid_o, 0);
      chk("rst_addr", wr_addr_o, 0);
      chk("rst_data", wr_data_o, 0);
      chk("rst_err", frame_err_o, 0);
      chk("rst_busy", busy_o, 0);
      rst = 1'b0;
      tick(5);

      // Good write, with strobe latency measured from nCS rising.
      mark();
      frame(17'h08255, 16, 12);
      chk("w8255_nwr", n_wr - wr0, 1);
      chk("w8255_nerr", n_err - err0, 0);
      chk("w8255_lat", pulse_cyc - rise_cyc, SYNC + 2);
      chk_wr("w8255", 7'h02, 8'h55);

      // Read frame is silently dropped; busy tracks the frame.
      mark();
      ncs_i = 1'b0;
      tick(1);
      send_bits(17'h00002, 8);
      chk("rd_busy_mid", busy_o, 1);
      send_bits(17'h00033, 8);
      end_frame(12);
      chk("rd_busy_after", busy_o, 0);
      chk("rd_nwr", n_wr - wr0, 0);
      chk("rd_nerr", n_err - err0, 0);
      chk("hold_addr", wr_addr_o, 7'h02);
      chk("hold_data", wr_data_o, 8'h55);

      // Short and long frames each raise one error.
      mark();
      frame(17'h00255, 15, 12);
      chk("b15_nerr", n_err - err0, 1);
      chk("b15_lat", pulse_cyc - rise_cyc, SYNC + 2);
      frame(17'h10255, 17, 12);
      chk("b17_nerr", n_err - err0, 2);
      chk("b15_17_nwr", n_wr - wr0, 0);
      frame(17'h08011, 16, 12);
      chk("w8011_nwr", n_wr - wr0, 1);
      chk_wr("w8011", 7'h00, 8'h11);

      // Out-of-range address.
      mark();
      frame(17'h085AA, 16, 12);
      chk("a5_nwr", n_wr - wr0, 0);
`ifdef SPI_FRAME_RX_ADDR_ERR_EN
      chk("a5_nerr", n_err - err0, 1);
`else
      chk("a5_nerr", n_err - err0, 0);
`endif

      // Reset in the middle of a frame.
      frame(17'h08123, 16, 12);
      chk_wr("w8123", 7'h01, 8'h23);
      mark();
      ncs_i = 1'b0;
      tick(1);
      send_bits(17'h00081, 8);
      sclk_i = 1'b0;
      tick(HALF);
      rst = 1'b1;
      #1;
      chk("mid_rst_addr", wr_addr_o, 0);
      chk("mid_rst_data", wr_data_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      tick(2);
      rst = 1'b0;
      send_bits(17'h00077, 8);
      end_frame(12);
      chk("mid_rst_nwr", n_wr - wr0, 0);
      chk("mid_rst_nerr", n_err - err0, 1);
      chk("mid_rst_q", q_addr.size(), 0);

      // Back-to-back frames with a 2-cycle nCS gap.
      mark();
      frame(17'h08101, 16, 2);
      frame(17'h08302, 16, 12);
      chk("b2b_nwr", n_wr - wr0, 2);
      chk("b2b_nerr", n_err - err0, 0);
      chk_wr("b2b_first", 7'h01, 8'h01);
      chk_wr("b2b_second", 7'h03, 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
